// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD seven-segment display scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0    = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h10;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_OFF  = 7'h7F;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_n_o = SEG_0;
            4'd1:    seg_n_o = SEG_1;
            4'd2:    seg_n_o = SEG_2;
            4'd3:    seg_n_o = SEG_3;
            4'd4:    seg_n_o = SEG_4;
            4'd5:    seg_n_o = SEG_5;
            4'd6:    seg_n_o = SEG_6;
            4'd7:    seg_n_o = SEG_7;
            4'd8:    seg_n_o = SEG_8;
            4'd9:    seg_n_o = SEG_9;
            default: seg_n_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with frame-synchronous
// loading, leading-zero blanking, invalid-code dash and anode dead time.
module bcd_display_scanner
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [BCD_W*DIGITS-1:0]       digits_in,
    input  logic [DIGITS-1:0]             dp_in,
    input  logic                          load,
    output logic [SEG_W-1:0]              seg_n,
    output logic                          dp_n,
    output logic [DIGITS-1:0]             an_n,
    output logic [idx_width(DIGITS)-1:0]  slot,
    output logic                          frame_done
);

    localparam int unsigned SLOT_W = idx_width(DIGITS);
    localparam int unsigned DIV_W  = idx_width(SCAN_DIV);
    localparam int unsigned DATA_W = BCD_W * DIGITS;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic              pending_q, pending_d;

    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_n_q, dp_n_d;
    logic [DIGITS-1:0] an_n_q, an_n_d;
    logic [SLOT_W-1:0] slot_out_q;
    logic              frame_done_q;

    logic              tick;
    logic              last_slot;
    logic              boundary;

    logic [BCD_W-1:0]  sel_dig;
    logic              sel_dp;
    logic              sel_blank;
    logic              lz_run;
    logic              blank_k;
    logic [SEG_W-1:0]  dec_seg;

    assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
    assign last_slot = (slot_q == SLOT_W'(DIGITS - 1));
    assign boundary  = tick && last_slot;

    // Prescaler, slot counter and the shadow/display handoff.
    always_comb begin
        div_d       = tick ? '0 : div_q + DIV_W'(1);
        slot_d      = slot_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;

        if (tick) begin
            slot_d = last_slot ? '0 : slot_q + SLOT_W'(1);
        end

        if (boundary) begin
            // A load landing on the boundary itself beats anything still pending.
            if (load) begin
                disp_d    = digits_in;
                disp_dp_d = dp_in;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d    = digits_in;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end
    end

    // Select the scanned digit; blanking walks down from the top digit while it stays zero.
    always_comb begin
        sel_dig   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        lz_run    = 1'b1;
        blank_k   = 1'b0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            lz_run  = lz_run && (disp_q[BCD_W*k +: BCD_W] == '0);
            blank_k = BLANK_LZ && (k > 0) && lz_run && !disp_dp_q[k];
            if (slot_q == SLOT_W'(k)) begin
                sel_dig   = disp_q[BCD_W*k +: BCD_W];
                sel_dp    = disp_dp_q[k];
                sel_blank = blank_k;
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd_i   (sel_dig),
        .seg_n_o (dec_seg)
    );

    always_comb begin
        seg_d  = sel_blank ? SEG_OFF : dec_seg;
        dp_n_d = ~sel_dp;
        an_n_d = (div_q == '0) ? '1 : ~(DIGITS'(1) << slot_q);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            div_q        <= '0;
            slot_q       <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            shadow_q     <= '0;
            shadow_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            slot_out_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            slot_q       <= slot_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            slot_out_q   <= slot_q;
            frame_done_q <= boundary;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign slot       = slot_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: cycle-accurate reference model
// derived from absolute cycle count, plus directed frame checks and random loads.
module tb_bcd_display_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        load;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  slot;
    logic        frame_done;

    bcd_display_scanner #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1'b1)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .slot       (slot),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    logic [3:0] an_ref [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Reference state: n counts rising edges since reset release.
    int          n;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_ddp, m_sdp;
    bit          m_pend;
    int          ones_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_blank(input logic [15:0] d, input logic [3:0] p, input int k);
        return (k > 0) && ((d >> (4 * k)) == 16'd0) && !p[k];
    endfunction

    task automatic model_reset();
        n        = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_ddp    = '0;
        m_sdp    = '0;
        m_pend   = 1'b0;
    endtask

    task automatic drive(input logic ld, input logic [15:0] d, input logic [3:0] p);
        load      = ld;
        digits_in = d;
        dp_in     = p;
    endtask

    // One clock edge: predict outputs from pre-edge state, advance model, compare.
    task automatic step();
        int         dv, sl;
        bit         bnd;
        logic [3:0] dig;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dpn;
        @(posedge clock);
        dv    = n % SCAN_DIV;
        sl    = (n / SCAN_DIV) % DIGITS;
        bnd   = (n % FRAME) == FRAME - 1;
        dig   = m_disp[4*sl +: 4];
        e_seg = ref_blank(m_disp, m_ddp, sl) ? 7'h7F : seg_ref[dig];
        e_an  = (dv == 0) ? 4'hF : ~(4'b0001 << sl);
        e_dpn = ~m_ddp[sl];
        if (bnd) begin
            if (load) begin
                m_disp = digits_in;
                m_ddp  = dp_in;
            end else if (m_pend) begin
                m_disp = m_shadow;
                m_ddp  = m_sdp;
            end
            m_pend = 1'b0;
        end else if (load) begin
            m_shadow = digits_in;
            m_sdp    = dp_in;
            m_pend   = 1'b1;
        end
        n++;
        #1;
        chk("an_n", 32'(an_n), 32'(e_an));
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n", 32'(dp_n), 32'(e_dpn));
        chk("slot", 32'(slot), 32'(sl));
        chk("frame_done", 32'(frame_done), 32'(bnd));
        if (an_n != 4'hF && seg_n == 7'h79) ones_seen++;
    endtask

    task automatic run_to_boundary();
        int guard = 0;
        do begin
            step();
            guard++;
        end while ((n % FRAME) != 0 && guard <= FRAME);
    endtask

    // Capture one full frame; es packs slot0 in bits [6:0], edpn bit k is dp_n of slot k.
    task automatic frame_check(input string tag, input logic [27:0] es, input logic [3:0] edpn);
        logic [6:0] o_seg [4];
        logic [3:0] o_an  [4];
        logic       o_dp  [4];
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (i % SCAN_DIV == 1) begin
                o_seg[i / SCAN_DIV] = seg_n;
                o_an[i / SCAN_DIV]  = an_n;
                o_dp[i / SCAN_DIV]  = dp_n;
            end
        end
        for (int k = 0; k < DIGITS; k++) begin
            chk({tag, "_seg", 8'(48 + k)}, 32'(o_seg[k]), 32'(es[7*k +: 7]));
            chk({tag, "_an", 8'(48 + k)}, 32'(o_an[k]), 32'(an_ref[k]));
            chk({tag, "_dp", 8'(48 + k)}, 32'(o_dp[k]), 32'(edpn[k]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, 32'(an_n), 32'h0000_000F);
        chk({tag, "_seg"}, 32'(seg_n), 32'h0000_007F);
        chk({tag, "_dp"}, 32'(dp_n), 32'h0000_0001);
        chk({tag, "_fd"}, 32'(frame_done), 32'h0000_0000);
    endtask

    // Asynchronous clear between edges; loads during reset must be ignored.
    task automatic do_reset();
        #2;
        clear = 1'b1;
        drive(1'b1, 16'h9876, 4'hF);
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("rst_hold");
        clear = 1'b0;
        drive(1'b0, 16'h0000, 4'h0);
        model_reset();
        step();
        step();
        chk("rst_first_an", 32'(an_n), 32'h0000_000E);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_cnt, dead_cnt, multi_cnt;
        clear = 1'b1;
        ones_seen = 0;
        drive(1'b0, 16'h0000, 4'h0);
        model_reset();
        #1;
        check_reset_outputs("rst_init");
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst_init_hold");
        clear = 1'b0;
        repeat (7) step();
        do_reset();

        // Basic scan
        repeat (3) step();
        drive(1'b1, 16'h1234, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        run_to_boundary();
        frame_check("basic", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);

        // Leading-zero blanking
        repeat (5) step();
        drive(1'b1, 16'h0070, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        run_to_boundary();
        frame_check("lz70", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF);

        drive(1'b1, 16'h0000, 4'h4); step(); drive(1'b0, 16'h0, 4'h0);
        run_to_boundary();
        frame_check("lzdp", {7'h7F, 7'h40, 7'h7F, 7'h40}, 4'hB);

        // Invalid code
        repeat (2) step();
        drive(1'b1, 16'h00A5, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        run_to_boundary();
        frame_check("inval", {7'h7F, 7'h7F, 7'h3F, 7'h12}, 4'hF);

        // Anti-tearing: last load before the boundary wins
        repeat (3) step();
        ones_seen = 0;
        drive(1'b1, 16'h1111, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        repeat (4) step();
        drive(1'b1, 16'h2222, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        run_to_boundary();
        frame_check("tear", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);
        chk("tear_no_1111", 32'(ones_seen), 32'd0);

        // Load on the boundary edge overrides a pending shadow
        repeat (2) step();
        drive(1'b1, 16'h9999, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        for (int g = 0; g < FRAME && (n % FRAME) != FRAME - 1; g++) step();
        drive(1'b1, 16'h5678, 4'h0); step(); drive(1'b0, 16'h0, 4'h0);
        frame_check("coinc", {7'h12, 7'h02, 7'h78, 7'h00}, 4'hF);

        // Cadence over 64 cycles
        fd_cnt = 0; dead_cnt = 0; multi_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_done) fd_cnt++;
            if (an_n == 4'hF) dead_cnt++;
            if ($countones(~an_n) > 1) multi_cnt++;
        end
        chk("cad_frame_done", 32'(fd_cnt), 32'd4);
        chk("cad_dead", 32'(dead_cnt), 32'd16);
        chk("cad_multi_an", 32'(multi_cnt), 32'd0);

        // Randomized loads with leading zeros, invalid codes and dp bits
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] rd;
            logic [3:0]  rp;
            rd = 16'($urandom) >> (4 * $urandom_range(0, 3));
            rp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            drive($urandom_range(0, 7) == 0, rd, rp);
            step();
            if (i == 777) begin
                drive(1'b1, rd, rp);
                step();
                do_reset();
            end
        end
        drive(1'b0, 16'h0, 4'h0);
        repeat (FRAME) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
